// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and FSM state type for the 5x5 serial convolution MAC
package conv_pkg;

    localparam int TAPS  = 25;
    localparam int W_W   = 32;
    localparam int PIX_W = 8;
    localparam int ACC_W = 48;
    localparam int IDX_W = 5;
    localparam int PROD_W = W_W + PIX_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } convState_t;

endpackage

// File: rtl/conv_mac_core.sv
// rtl/conv_mac_core.sv - tap mux, signed weight x unsigned pixel multiply, wrapping accumulator
module conv_mac_core
    import conv_pkg::*;
(
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [TAPS*W_W-1:0]   iWeights,
    input  logic [PIX_W-1:0]      iPixel,
    input  logic [IDX_W-1:0]      iIdx,
    input  logic                  iLoad,
    input  logic                  iAdd,
    input  logic                  iClear,
    output logic [ACC_W-1:0]      oSum
);

    logic signed [W_W-1:0]    tapWeight;
    logic signed [PIX_W:0]    pixSigned;
    logic signed [PROD_W-1:0] product;
    logic [ACC_W-1:0]         productExt;
    logic [ACC_W-1:0]         acc;

    always_comb begin
        tapWeight = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (iIdx == IDX_W'(k)) begin
                tapWeight = iWeights[k*W_W +: W_W];
            end
        end
    end

    // Zero-extend the pixel by one bit so the signed multiply treats it as non-negative.
    assign pixSigned  = {1'b0, iPixel};
    assign product    = tapWeight * pixSigned;
    assign productExt = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};

    // The first beat of a window starts from the product alone, discarding the stale sum.
    assign oSum = iLoad ? productExt : (acc + productExt);

    always_ff @(posedge iCLK) begin
        if (iRST || iClear) begin
            acc <= '0;
        end else if (iLoad || iAdd) begin
            acc <= oSum;
        end
    end

endmodule

// File: rtl/conv5x5_serial_mac.sv
// rtl/conv5x5_serial_mac.sv - 5x5 window serial MAC with valid/ready in/out; CONV_RELU_EN clamps negative results to zero
module conv5x5_serial_mac
    import conv_pkg::*;
(
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [TAPS*W_W-1:0]   iWeights,
    input  logic                  iFlush,
    input  logic                  iPixValid,
    input  logic [PIX_W-1:0]      iPixel,
    output logic                  oPixReady,
    output logic                  oValid,
    output logic [ACC_W-1:0]      oResult,
    input  logic                  iReady,
    output logic                  oBusy
);

    convState_t       state;
    logic [IDX_W-1:0] idx;
    logic             beat;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] resultNext;

    assign oPixReady = !iRST && (state != OUT);
    assign oBusy     = (state != IDLE);
    assign beat      = iPixValid && oPixReady;

    conv_mac_core uCore (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iWeights (iWeights),
        .iPixel   (iPixel),
        .iIdx     (idx),
        .iLoad    (beat && (state == IDLE) && !iFlush),
        .iAdd     (beat && (state == ACCUM) && !iFlush),
        .iClear   (iFlush),
        .oSum     (sum)
    );

`ifdef CONV_RELU_EN
    assign resultNext = sum[ACC_W-1] ? '0 : sum;
`else
    assign resultNext = sum;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= IDLE;
            idx     <= '0;
            oValid  <= 1'b0;
            oResult <= '0;
        end else if (iFlush) begin
            // Flush wins over a coincident beat or handshake; oResult keeps its last value.
            state  <= IDLE;
            idx    <= '0;
            oValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        idx   <= idx + 1'b1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        if (idx == LAST_IDX) begin
                            idx     <= '0;
                            oValid  <= 1'b1;
                            oResult <= resultNext;
                            state   <= OUT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    idx    <= '0;
                    oValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
